mem_arbiter_2p: RTL and testbench
=================================

# mem_arbiter_2p

Two-port arbiter that shares one single-ported synchronous memory (the `memory_bysize` style: `cs`/`wen`/`addr`/`din`, registered `dout` one clock after the access) between two requesters, e.g. CPU data port and a DMA/video fetch unit. It selects one request per cycle, registers the memory command, and routes the read data back to the winning port with a fixed latency. It sits between the requesters and the memory instance inside the computer top level.

## Interface
- `WIDTH`, 32: data width in bits, equal to the memory cell width.
- `RR`, 1: 1 selects round-robin arbitration; 0 selects fixed priority with port A winning.
- `MAXWAIT`, 4: used only when `RR`=0. This is the number of consecutive lost arbitrations after which port B is forced to win. Legal range is 1..15.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `a_req` in 1: port A request.
- `a_wen` in 1: 1 means write, 0 means read.
- `a_addr` in 32: word address.
- `a_wdata` in WIDTH: write data.
- `a_gnt` out 1: combinational; request accepted this cycle.
- `a_rvalid` out 1: registered; read data valid.
- `a_rdata` out WIDTH: registered read data.
- `b_req`, `b_wen`, `b_addr`, `b_wdata`, `b_gnt`, `b_rvalid`, `b_rdata`: identical to the port A signals, for port B.
- `m_cs` out 1: registered memory chip select.
- `m_wen` out 1: registered memory write enable.
- `m_addr` out 32: registered memory address.
- `m_din` out WIDTH: registered memory write data.
- `m_dout` in WIDTH: memory read data, valid in the cycle after the memory samples `m_cs`.

## Operation
- Handshake:
  - A requester asserts `x_req` with its `wen`/`addr`/`wdata` and holds all of them stable until `x_gnt`=1.
  - The transfer happens in the cycle where `x_req` and `x_gnt` are both 1.
  - A requester may issue back-to-back requests.
- Grant rules (combinational from `req` and registered state):
  - At most one grant per cycle; `x_gnt` is never asserted without `x_req`.
  - Only one port requesting: that port wins.
  - Both requesting with `RR`=1: the port that did not win the most recent grant wins. Register `last`, reset value = B, so A wins the first tie.
  - Both requesting with `RR`=0: A wins, unless `wait_cnt` equals `MAXWAIT`, in which case B wins.
- `wait_cnt` (4-bit, used only when `RR`=0):
  - Increments when `b_req`=1 and B is not granted.
  - Clears when B is granted or `b_req`=0.
  - Saturates at `MAXWAIT`.
- Command stage (registered at the edge ending the grant cycle):
  - `m_cs` = any grant.
  - `m_wen`, `m_addr`, `m_din` = the winner's fields.
  - `m_cs`=0 when there is no grant; `m_wen`, `m_addr`, `m_din` are then don't-care but must hold their previous values.
- Tag pipeline: two registered stages carry {valid, is_read, port}, aligned to the command and to `m_dout`.
- Response stage:
  - When stage-2 valid and is_read are both set, capture `m_dout` into `x_rdata` of the tagged port and pulse `x_rvalid` for one cycle.
  - The other port's `rdata` holds its value.
- Writes produce no `rvalid`; the grant is the completion.
- Ordering: commands reach memory in grant order. A read granted after a write to the same address returns the new data.

## Timing
- Grant in cycle N:
  - `m_*` valid in cycle N+1; the memory samples at the end of N+1.
  - `m_dout` is valid in N+2.
  - `x_rvalid`/`x_rdata` are valid in N+3.
- Read latency is 3 cycles from grant. Throughput is one access per cycle, with no bubbles between ports.
- Reset (asynchronous assert, synchronous release):
  - `m_cs`, `m_wen`, `a_rvalid`, `b_rvalid` = 0.
  - `m_addr`, `m_din`, `a_rdata`, `b_rdata` = 0.
  - Tags invalid, `last` = B, `wait_cnt` = 0.
- Reset asserted mid-operation: in-flight reads are discarded, and no `rvalid` appears after release.
- While `reset_n`=0, `a_gnt` and `b_gnt` are 0.

## Test plan
- **Single read:** preload mem[0x10]=0xDEADBEEF; A reads 0x10 in cycle 5 → `a_gnt`=1 in cycle 5, `m_cs`=1 with `m_addr`=0x10 in cycle 6, `a_rvalid`=1 with `a_rdata`=0xDEADBEEF in cycle 8, `b_rvalid` stays 0.
- **Round-robin tie (`RR`=1):** A and B request reads continuously for 6 cycles → grants alternate A,B,A,B,A,B; responses arrive at the matching ports in the same order, 3 cycles after each grant.
- **Write then read:** A writes 0x55 to 0x20, then B reads 0x20 in the next cycle → `b_rdata`=0x55; no `rvalid` on A for the write.
- **Starvation guard (`RR`=0, `MAXWAIT`=4):** A and B both request continuously → pattern A,A,A,A,B repeating; `wait_cnt` clears on each B grant.
- **Hold stability:** B's request is held across 3 lost cycles with fixed fields → exactly one memory access for B; `m_addr` matches B's field.
- **Reset mid-read:** assert `reset_n`=0 one cycle after an A read grant → all outputs at their reset values, and no `a_rvalid` after release.

Source files
------------

// File: rtl/mem_arbiter_2p.sv
// mem_arbiter_2p: shares one single-ported synchronous memory between two
// requesters. One request is granted per cycle. The memory command is
// registered, and read data returns to the winning port three cycles after
// its grant.
module mem_arbiter_2p #(
  parameter int WIDTH   = 32,
  parameter bit RR      = 1'b1,
  parameter int MAXWAIT = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  // Port A
  input  logic             a_req,
  input  logic             a_wen,
  input  logic [31:0]      a_addr,
  input  logic [WIDTH-1:0] a_wdata,
  output logic             a_gnt,
  output logic             a_rvalid,
  output logic [WIDTH-1:0] a_rdata,
  // Port B
  input  logic             b_req,
  input  logic             b_wen,
  input  logic [31:0]      b_addr,
  input  logic [WIDTH-1:0] b_wdata,
  output logic             b_gnt,
  output logic             b_rvalid,
  output logic [WIDTH-1:0] b_rdata,
  // Memory side
  output logic             m_cs,
  output logic             m_wen,
  output logic [31:0]      m_addr,
  output logic [WIDTH-1:0] m_din,
  input  logic [WIDTH-1:0] m_dout
);

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_e;

  typedef struct packed {
    logic  valid;
    logic  is_read;
    port_e port;
  } tag_t;

  localparam logic [3:0] MAXWAIT_C = 4'(MAXWAIT);

  port_e            last_q;
  logic [3:0]       wait_cnt_q;
  tag_t             tag1_q;
  tag_t             tag2_q;
  tag_t             tag_d;

  logic             any_gnt;
  port_e            sel_port;
  logic             sel_wen;
  logic [31:0]      sel_addr;
  logic [WIDTH-1:0] sel_wdata;

  // Pick at most one winner per cycle; no grants at all while reset is held
  always_comb begin
    a_gnt = 1'b0;
    b_gnt = 1'b0;
    if (reset_n) begin
      if (a_req && b_req) begin
        if (RR) begin
          if (last_q == PORT_B) a_gnt = 1'b1;
          else                  b_gnt = 1'b1;
        end else begin
          if (wait_cnt_q == MAXWAIT_C) b_gnt = 1'b1;
          else                         a_gnt = 1'b1;
        end
      end else begin
        a_gnt = a_req;
        b_gnt = b_req;
      end
    end
  end

  // Steer the winner's command fields toward the command register
  always_comb begin
    any_gnt   = a_gnt | b_gnt;
    sel_port  = b_gnt ? PORT_B : PORT_A;
    sel_wen   = b_gnt ? b_wen   : a_wen;
    sel_addr  = b_gnt ? b_addr  : a_addr;
    sel_wdata = b_gnt ? b_wdata : a_wdata;
    tag_d     = '{valid: any_gnt, is_read: ~sel_wen, port: sel_port};
  end

  // Remember the most recent winner so round-robin ties alternate
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)     last_q <= PORT_B;
    else if (any_gnt) last_q <= sel_port;
  end

  // Count consecutive lost arbitrations of B; saturating at MAXWAIT forces B through
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt_q <= 4'd0;
    end else if (b_req && !b_gnt) begin
      if (wait_cnt_q != MAXWAIT_C) wait_cnt_q <= wait_cnt_q + 4'd1;
    end else begin
      wait_cnt_q <= 4'd0;
    end
  end

  // Register the memory command; idle cycles keep the previous fields
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_cs   <= 1'b0;
      m_wen  <= 1'b0;
      m_addr <= '0;
      m_din  <= '0;
    end else begin
      m_cs <= any_gnt;
      if (any_gnt) begin
        m_wen  <= sel_wen;
        m_addr <= sel_addr;
        m_din  <= sel_wdata;
      end
    end
  end

  // Two-deep tag pipe: stage 1 aligns with the command, stage 2 with m_dout
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tag1_q <= '0;
      tag2_q <= '0;
    end else begin
      tag1_q <= tag_d;
      tag2_q <= tag1_q;
    end
  end

  // Return read data to the tagged port; the other port keeps its last data
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_rvalid <= 1'b0;
      b_rvalid <= 1'b0;
      a_rdata  <= '0;
      b_rdata  <= '0;
    end else begin
      a_rvalid <= tag2_q.valid && tag2_q.is_read && (tag2_q.port == PORT_A);
      b_rvalid <= tag2_q.valid && tag2_q.is_read && (tag2_q.port == PORT_B);
      if (tag2_q.valid && tag2_q.is_read && (tag2_q.port == PORT_A)) a_rdata <= m_dout;
      if (tag2_q.valid && tag2_q.is_read && (tag2_q.port == PORT_B)) b_rdata <= m_dout;
    end
  end

endmodule

// File: tb/tb_mem_arbiter_2p.sv
// tb_mem_arbiter_2p: drives a round-robin instance (index 0) and a
// fixed-priority MAXWAIT=4 instance (index 1) with the same requests. Each
// instance has its own behavioural memory.
module tb_mem_arbiter_2p;
  localparam int WIDTH = 32;

  logic clk = 1'b0;
  logic reset_n;
  logic mem_load;

  logic             a_req, a_wen, b_req, b_wen;
  logic [31:0]      a_addr, b_addr;
  logic [WIDTH-1:0] a_wdata, b_wdata;

  logic [1:0]            a_gnt_v, b_gnt_v, a_rvalid_v, b_rvalid_v, m_cs_v, m_wen_v;
  logic [1:0][WIDTH-1:0] a_rdata_v, b_rdata_v, m_din_v, m_dout_v;
  logic [1:0][31:0]      m_addr_v;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit chk_en = 1'b0;

  typedef struct {
    logic             a_req;
    logic             a_wen;
    logic [31:0]      a_addr;
    logic [WIDTH-1:0] a_wdata;
    logic             b_req;
    logic             b_wen;
    logic [31:0]      b_addr;
    logic [WIDTH-1:0] b_wdata;
    logic [1:0]       exp_a;
    logic [1:0]       exp_b;
  } vec_t;

  typedef struct {
    int               due;
    int               inst;
    logic             wen;
    logic [31:0]      addr;
    logic [WIDTH-1:0] din;
  } cmd_t;

  typedef struct {
    int               due;
    int               inst;
    int               port;
    logic [WIDTH-1:0] data;
  } rsp_t;

  cmd_t             cmd_q[$];
  rsp_t             rsp_q[$];
  logic [WIDTH-1:0] mdl_mem   [2][256];
  logic [WIDTH-1:0] exp_rdata [2][2];
  logic [WIDTH-1:0] mem       [2][256];

  // Free-running clock and a cycle counter used to time scoreboard entries
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  mem_arbiter_2p #(.WIDTH(WIDTH), .RR(1'b1), .MAXWAIT(4)) dut_rr (
    .clk(clk), .reset_n(reset_n),
    .a_req(a_req), .a_wen(a_wen), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt_v[0]), .a_rvalid(a_rvalid_v[0]), .a_rdata(a_rdata_v[0]),
    .b_req(b_req), .b_wen(b_wen), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt_v[0]), .b_rvalid(b_rvalid_v[0]), .b_rdata(b_rdata_v[0]),
    .m_cs(m_cs_v[0]), .m_wen(m_wen_v[0]), .m_addr(m_addr_v[0]),
    .m_din(m_din_v[0]), .m_dout(m_dout_v[0])
  );

  mem_arbiter_2p #(.WIDTH(WIDTH), .RR(1'b0), .MAXWAIT(4)) dut_fp (
    .clk(clk), .reset_n(reset_n),
    .a_req(a_req), .a_wen(a_wen), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt_v[1]), .a_rvalid(a_rvalid_v[1]), .a_rdata(a_rdata_v[1]),
    .b_req(b_req), .b_wen(b_wen), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt_v[1]), .b_rvalid(b_rvalid_v[1]), .b_rdata(b_rdata_v[1]),
    .m_cs(m_cs_v[1]), .m_wen(m_wen_v[1]), .m_addr(m_addr_v[1]),
    .m_din(m_din_v[1]), .m_dout(m_dout_v[1])
  );

  function automatic logic [WIDTH-1:0] initWord(int i);
    if (i == 16) return 32'hDEAD_BEEF;
    return 32'hA500_0000 | 32'(i);
  endfunction

  // Synchronous single-port memories, registered dout one clock after cs
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (mem_load) begin
        for (int i = 0; i < 256; i++) mem[k][i] <= initWord(i);
      end else if (m_cs_v[k]) begin
        if (m_wen_v[k]) mem[k][m_addr_v[k][7:0]] <= m_din_v[k];
        else            m_dout_v[k] <= mem[k][m_addr_v[k][7:0]];
      end
    end
  end

  function automatic vec_t mk(logic ar, logic aw, logic [31:0] aa, logic [31:0] ad,
                              logic br, logic bw, logic [31:0] ba, logic [31:0] bd,
                              logic [1:0] ea, logic [1:0] eb);
    vec_t v;
    v.a_req = ar; v.a_wen = aw; v.a_addr = aa; v.a_wdata = ad;
    v.b_req = br; v.b_wen = bw; v.b_addr = ba; v.b_wdata = bd;
    v.exp_a = ea; v.exp_b = eb;
    return v;
  endfunction

  task automatic checkVal(string name, int inst, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s inst%0d cycle %0d: got %h expected %h", name, inst, cyc, act, exp);
    end
  endtask

  task automatic pushGrant(int k, int port, logic wen, logic [31:0] addr, logic [WIDTH-1:0] wdata);
    cmd_q.push_back('{due: cyc + 1, inst: k, wen: wen, addr: addr, din: wdata});
    if (wen) mdl_mem[k][addr[7:0]] = wdata;
    else     rsp_q.push_back('{due: cyc + 3, inst: k, port: port, data: mdl_mem[k][addr[7:0]]});
  endtask

  // Drive one cycle of requests, check grants, and queue what must follow
  task automatic applyStimulus(input vec_t v);
    @(posedge clk);
    #1;
    a_req = v.a_req; a_wen = v.a_wen; a_addr = v.a_addr; a_wdata = v.a_wdata;
    b_req = v.b_req; b_wen = v.b_wen; b_addr = v.b_addr; b_wdata = v.b_wdata;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      checkVal("a_gnt", k, 32'(a_gnt_v[k]), 32'(v.exp_a[k]));
      checkVal("b_gnt", k, 32'(b_gnt_v[k]), 32'(v.exp_b[k]));
      if (v.exp_a[k]) pushGrant(k, 0, v.a_wen, v.a_addr, v.a_wdata);
      if (v.exp_b[k]) pushGrant(k, 1, v.b_wen, v.b_addr, v.b_wdata);
    end
  endtask

  // Pop scoreboard entries due this cycle; anything not due must be idle
  task automatic checkOutput();
    logic [1:0]      got_cmd;
    logic [1:0][1:0] got_rsp;
    cmd_t c;
    rsp_t r;
    if (!reset_n) begin
      cmd_q.delete();
      rsp_q.delete();
      for (int k = 0; k < 2; k++) begin
        exp_rdata[k][0] = '0;
        exp_rdata[k][1] = '0;
      end
      return;
    end
    if (!chk_en) return;
    got_cmd = '0;
    got_rsp = '0;
    while (cmd_q.size() > 0 && cmd_q[0].due <= cyc) begin
      c = cmd_q.pop_front();
      got_cmd[c.inst] = 1'b1;
      checkVal("m_cs", c.inst, 32'(m_cs_v[c.inst]), 32'd1);
      checkVal("m_wen", c.inst, 32'(m_wen_v[c.inst]), 32'(c.wen));
      checkVal("m_addr", c.inst, m_addr_v[c.inst], c.addr);
      checkVal("m_din", c.inst, m_din_v[c.inst], c.din);
    end
    while (rsp_q.size() > 0 && rsp_q[0].due <= cyc) begin
      r = rsp_q.pop_front();
      got_rsp[r.inst][r.port] = 1'b1;
      exp_rdata[r.inst][r.port] = r.data;
    end
    for (int k = 0; k < 2; k++) begin
      if (!got_cmd[k]) checkVal("m_cs_idle", k, 32'(m_cs_v[k]), 32'd0);
      checkVal("a_rvalid", k, 32'(a_rvalid_v[k]), 32'(got_rsp[k][0]));
      checkVal("b_rvalid", k, 32'(b_rvalid_v[k]), 32'(got_rsp[k][1]));
      checkVal("a_rdata", k, a_rdata_v[k], exp_rdata[k][0]);
      checkVal("b_rdata", k, b_rdata_v[k], exp_rdata[k][1]);
    end
  endtask

  task automatic checkResetState();
    for (int k = 0; k < 2; k++) begin
      checkVal("rst_a_gnt", k, 32'(a_gnt_v[k]), 32'd0);
      checkVal("rst_b_gnt", k, 32'(b_gnt_v[k]), 32'd0);
      checkVal("rst_m_cs", k, 32'(m_cs_v[k]), 32'd0);
      checkVal("rst_m_wen", k, 32'(m_wen_v[k]), 32'd0);
      checkVal("rst_m_addr", k, m_addr_v[k], 32'd0);
      checkVal("rst_m_din", k, m_din_v[k], 32'd0);
      checkVal("rst_a_rvalid", k, 32'(a_rvalid_v[k]), 32'd0);
      checkVal("rst_b_rvalid", k, 32'(b_rvalid_v[k]), 32'd0);
      checkVal("rst_a_rdata", k, a_rdata_v[k], 32'd0);
      checkVal("rst_b_rdata", k, b_rdata_v[k], 32'd0);
    end
  endtask

  // Output monitor runs on the falling edge, away from the active edge
  always @(negedge clk) checkOutput();

  // Main sequence: reset, vector table, then reset during an in-flight read
  initial begin
    vec_t vecs[$];
    vec_t idle;
    logic rr_a, fp_b;

    reset_n  = 1'b0;
    mem_load = 1'b1;
    a_req = 1'b0; a_wen = 1'b0; a_addr = '0; a_wdata = '0;
    b_req = 1'b0; b_wen = 1'b0; b_addr = '0; b_wdata = '0;
    for (int i = 0; i < 256; i++) begin
      mdl_mem[0][i] = initWord(i);
      mdl_mem[1][i] = initWord(i);
    end

    // exp_a / exp_b bit 0 = round-robin instance, bit 1 = fixed-priority instance
    idle = mk(0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0, 2'b00, 2'b00);
    // Continuous tie: RR alternates A,B; fixed priority gives A,A,A,A,B
    for (int i = 0; i < 10; i++) begin
      rr_a = (i % 2 == 0);
      fp_b = (i == 4) || (i == 9);
      vecs.push_back(mk(1, 0, 32'h01, 32'h1111_0001, 1, 0, 32'h02, 32'h2222_0002,
                        {~fp_b, rr_a}, {fp_b, ~rr_a}));
    end
    // Single read of the preloaded word
    vecs.push_back(mk(1, 0, 32'h10, 32'h0, 0, 0, 32'h0, 32'h0, 2'b11, 2'b00));
    repeat (3) vecs.push_back(idle);
    // Write from A, then B reads the same address
    vecs.push_back(mk(1, 1, 32'h20, 32'h55, 0, 0, 32'h0, 32'h0, 2'b11, 2'b00));
    vecs.push_back(mk(0, 0, 32'h0, 32'h0, 1, 0, 32'h20, 32'h0, 2'b00, 2'b11));
    repeat (3) vecs.push_back(idle);
    // B held with fixed fields while losing to A
    vecs.push_back(mk(1, 0, 32'h03, 32'h0, 1, 0, 32'h30, 32'h3030, 2'b11, 2'b00));
    vecs.push_back(mk(1, 0, 32'h03, 32'h0, 1, 0, 32'h30, 32'h3030, 2'b10, 2'b01));
    vecs.push_back(mk(1, 0, 32'h03, 32'h0, 1, 0, 32'h30, 32'h3030, 2'b11, 2'b00));
    vecs.push_back(mk(0, 0, 32'h0, 32'h0, 1, 0, 32'h30, 32'h3030, 2'b00, 2'b11));
    repeat (3) vecs.push_back(idle);
    // Cross-port writes followed by cross-port reads
    vecs.push_back(mk(1, 1, 32'h40, 32'h1111_1111, 1, 1, 32'h41, 32'h2222_2222, 2'b11, 2'b00));
    vecs.push_back(mk(0, 0, 32'h0, 32'h0, 1, 1, 32'h41, 32'h2222_2222, 2'b00, 2'b11));
    vecs.push_back(mk(1, 0, 32'h41, 32'h0, 1, 0, 32'h40, 32'h0, 2'b11, 2'b00));
    vecs.push_back(mk(0, 0, 32'h0, 32'h0, 1, 0, 32'h40, 32'h0, 2'b00, 2'b11));
    repeat (4) vecs.push_back(idle);

    repeat (3) @(posedge clk);
    #1;
    mem_load = 1'b0;
    a_req = 1'b1;
    b_req = 1'b1;
    @(negedge clk);
    checkResetState();
    @(posedge clk);
    #1;
    a_req = 1'b0;
    b_req = 1'b0;
    reset_n = 1'b1;
    chk_en = 1'b1;

    for (int i = 0; i < vecs.size(); i++) applyStimulus(vecs[i]);

    // Reset one cycle after an A read grant: read must vanish
    applyStimulus(mk(1, 0, 32'h10, 32'h0, 0, 0, 32'h0, 32'h0, 2'b11, 2'b00));
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    b_req = 1'b1;
    @(negedge clk);
    checkResetState();
    @(posedge clk);
    #1;
    a_req = 1'b0;
    b_req = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (6) applyStimulus(idle);
    // First tie after reset goes to A on both instances
    applyStimulus(mk(1, 0, 32'h05, 32'h0, 1, 0, 32'h06, 32'h0, 2'b11, 2'b00));
    repeat (4) applyStimulus(idle);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
